// File: rtl/if_id_hazard_if.sv
// IF/ID pipeline bus: fetch-side inputs, hazard requests and the
// registered ID-side outputs plus the combinational pipeline enables.
//
// Enable semantics: a value on pc_if/instr_if is captured into IF/ID at
// a rising edge only when IF_ID_Write=1 in that cycle. PcWrite=1 lets
// the fetch stage advance. ID_EXE_Bubble=1 asks the next stage to zero
// its control fields for this cycle. The hazard inputs carry no
// handshake and act in the cycle they are asserted.
interface if_id_hazard_if;
    logic        Load_hazard;
    logic        Branch_hazard;
    logic [31:0] pc_if;
    logic [31:0] instr_if;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        PcWrite;
    logic        IF_ID_Write;
    logic        ID_EXE_Bubble;

    // Pipeline/hazard-controller side: drives fetch data and hazards.
    modport master (
        output Load_hazard, Branch_hazard, pc_if, instr_if,
        input  pc_id, instr_id, valid_id, PcWrite, IF_ID_Write, ID_EXE_Bubble
    );

    // IF/ID stage side.
    modport slave (
        input  Load_hazard, Branch_hazard, pc_if, instr_if,
        output pc_id, instr_id, valid_id, PcWrite, IF_ID_Write, ID_EXE_Bubble
    );
endinterface

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall, branch flush, event
// counters and a watchdog on over-long stall sequences.
module if_id_hazard_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          MAX_STALL = 1,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    if_id_hazard_if.slave    bus,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_error
);

    // Consecutive-stall counter only has to reach MAX_STALL+1.
    localparam int CONSEC_W = $clog2(MAX_STALL + 2);
    localparam logic [CONSEC_W-1:0] CONSEC_LIM = CONSEC_W'(MAX_STALL);
    localparam logic [CONSEC_W-1:0] CONSEC_SAT = CONSEC_W'(MAX_STALL + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_id_q, pc_id_d;
    logic [31:0]         instr_id_q, instr_id_d;
    logic                valid_id_q, valid_id_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic                stall_error_q, stall_error_d;

    logic do_flush;
    logic do_stall;

    // Action decode: branch flush wins over a load stall; reset masks both.
    always_comb begin
        do_flush = 1'b0;
        do_stall = 1'b0;
        if (!reset) begin
            do_flush = bus.Branch_hazard;
            do_stall = bus.Load_hazard && !bus.Branch_hazard;
        end
    end

    // Zero-latency pipeline enables derived from this cycle's action.
    always_comb begin
        bus.PcWrite       = 1'b1;
        bus.IF_ID_Write   = 1'b1;
        bus.ID_EXE_Bubble = 1'b0;
        if (reset || do_flush) begin
            bus.ID_EXE_Bubble = 1'b1;
        end else if (do_stall) begin
            bus.PcWrite       = 1'b0;
            bus.IF_ID_Write   = 1'b0;
            bus.ID_EXE_Bubble = 1'b1;
        end
    end

    // Next-state: FSM, IF/ID contents, counters and watchdog.
    always_comb begin
        state_d       = ST_RUN;
        pc_id_d       = bus.pc_if;
        instr_id_d    = bus.instr_if;
        valid_id_d    = 1'b1;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        consec_d      = '0;
        stall_error_d = stall_error_q;
        if (do_flush) begin
            state_d    = ST_FLUSH;
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (do_stall) begin
            state_d    = ST_STALL;
            pc_id_d    = pc_id_q;
            instr_id_d = instr_id_q;
            valid_id_d = valid_id_q;
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            // A stall entered with MAX_STALL already behind it is one too many.
            if (consec_q >= CONSEC_LIM) begin
                stall_error_d = 1'b1;
            end
            consec_d = (consec_q >= CONSEC_SAT) ? CONSEC_SAT : consec_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_id_q       <= '0;
            instr_id_q    <= NOP_INSTR;
            valid_id_q    <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            consec_q      <= '0;
            stall_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_id_q       <= pc_id_d;
            instr_id_q    <= instr_id_d;
            valid_id_q    <= valid_id_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            consec_q      <= consec_d;
            stall_error_q <= stall_error_d;
        end
    end

    assign bus.pc_id    = pc_id_q;
    assign bus.instr_id = instr_id_q;
    assign bus.valid_id = valid_id_q;
    assign state_o      = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign stall_error  = stall_error_q;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage (CNT_W=4, MAX_STALL=1).
module tb_if_id_hazard_stage;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic          stall_error;

    int checks = 0;
    int errors = 0;

    if_id_hazard_if bus ();

    if_id_hazard_stage #(
        .NOP_INSTR (32'h00000013),
        .MAX_STALL (1),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .state_o     (state_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .stall_error (stall_error)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic lh, input logic bh,
                         input logic [31:0] pc, input logic [31:0] ins);
        reset             = rst;
        bus.Load_hazard   = lh;
        bus.Branch_hazard = bh;
        bus.pc_if         = pc;
        bus.instr_if      = ins;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    bus.pc_id,         32'h0);
        chk({tag, "_instr"}, bus.instr_id,      32'h00000013);
        chk({tag, "_valid"}, 32'(bus.valid_id), 32'h0);
        chk({tag, "_state"}, 32'(state_o),      32'h0);
        chk({tag, "_scnt"},  32'(stall_cnt),    32'h0);
        chk({tag, "_fcnt"},  32'(flush_cnt),    32'h0);
        chk({tag, "_err"},   32'(stall_error),  32'h0);
    endtask

    initial begin
        // Reset with a load hazard present: hazard must be ignored.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000);
        chk("rst_pcw",   32'(bus.PcWrite),       32'h1);
        chk("rst_ifidw", 32'(bus.IF_ID_Write),   32'h1);
        chk("rst_bub",   32'(bus.ID_EXE_Bubble), 32'h1);
        tick();
        tick();
        chk_reset_vals("rst");

        // Normal capture.
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0050_0093);
        chk("norm_pcw", 32'(bus.PcWrite),       32'h1);
        chk("norm_bub", 32'(bus.ID_EXE_Bubble), 32'h0);
        tick();
        chk("norm_pc",    bus.pc_id,         32'h0000_0100);
        chk("norm_instr", bus.instr_id,      32'h0050_0093);
        chk("norm_valid", 32'(bus.valid_id), 32'h1);
        chk("norm_state", 32'(state_o),      32'h0);

        // Load IF/ID with pc 0x104, then one stall cycle.
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h00a0_0113);
        tick();
        chk("pre_pc", bus.pc_id, 32'h0000_0104);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0108, 32'h0020_8233);
        chk("stall_pcw",   32'(bus.PcWrite),       32'h0);
        chk("stall_ifidw", 32'(bus.IF_ID_Write),   32'h0);
        chk("stall_bub",   32'(bus.ID_EXE_Bubble), 32'h1);
        tick();
        chk("stall_pc",    bus.pc_id,         32'h0000_0104);
        chk("stall_instr", bus.instr_id,      32'h00a0_0113);
        chk("stall_valid", 32'(bus.valid_id), 32'h1);
        chk("stall_state", 32'(state_o),      32'h1);
        chk("stall_scnt",  32'(stall_cnt),    32'h1);
        chk("stall_err",   32'(stall_error),  32'h0);

        // Branch with simultaneous load, right after a stall.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678);
        chk("fl_pcw",   32'(bus.PcWrite),       32'h1);
        chk("fl_ifidw", 32'(bus.IF_ID_Write),   32'h1);
        chk("fl_bub",   32'(bus.ID_EXE_Bubble), 32'h1);
        tick();
        chk("fl_instr", bus.instr_id,      32'h0000_0013);
        chk("fl_valid", 32'(bus.valid_id), 32'h0);
        chk("fl_pc",    bus.pc_id,         32'h0000_0200);
        chk("fl_state", 32'(state_o),      32'h2);
        chk("fl_fcnt",  32'(flush_cnt),    32'h1);
        chk("fl_scnt",  32'(stall_cnt),    32'h1);

        // Back-to-back branch.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_1111);
        tick();
        chk("fl2_pc",    bus.pc_id,      32'h0000_0204);
        chk("fl2_instr", bus.instr_id,   32'h0000_0013);
        chk("fl2_fcnt",  32'(flush_cnt), 32'h2);
        chk("fl2_state", 32'(state_o),   32'h2);

        // Back to normal.
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0010_0073);
        tick();
        chk("run_valid", 32'(bus.valid_id), 32'h1);
        chk("run_instr", bus.instr_id,      32'h0010_0073);
        chk("run_state", 32'(state_o),      32'h0);

        // Two consecutive stalls trip the watchdog on the second edge.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0304, 32'h0000_2222);
        tick();
        chk("wd1_scnt", 32'(stall_cnt),   32'h2);
        chk("wd1_err",  32'(stall_error), 32'h0);
        chk("wd1_pc",   bus.pc_id,        32'h0000_0300);
        tick();
        chk("wd2_scnt",  32'(stall_cnt),   32'h3);
        chk("wd2_err",   32'(stall_error), 32'h1);
        chk("wd2_state", 32'(state_o),     32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0308, 32'h0000_3333);
        tick();
        chk("wd3_err",   32'(stall_error), 32'h1);
        chk("wd3_state", 32'(state_o),     32'h0);
        chk("wd3_pc",    bus.pc_id,        32'h0000_0308);

        // 17 more flushes: count goes 2 -> 15 after 13, then stays at 15.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_4444);
        for (int i = 0; i < 12; i++) tick();
        chk("sat_fcnt14", 32'(flush_cnt), 32'he);
        tick();
        chk("sat_fcnt15", 32'(flush_cnt), 32'hf);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_fcnt_hold", 32'(flush_cnt), 32'hf);
        chk("sat_scnt",      32'(stall_cnt), 32'h3);

        // Reset during a load-hazard cycle.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_5555);
        chk("rst2_pcw",   32'(bus.PcWrite),       32'h1);
        chk("rst2_ifidw", 32'(bus.IF_ID_Write),   32'h1);
        chk("rst2_bub",   32'(bus.ID_EXE_Bubble), 32'h1);
        tick();
        chk_reset_vals("rst2");

        // Single stall after reset must not trip the watchdog.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_6666);
        tick();
        chk("post_err",  32'(stall_error), 32'h0);
        chk("post_scnt", 32'(stall_cnt),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
